ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 32, address width of masters and RAM port.
REQ-002 Parameter DW, default 32, data width of masters and RAM port.
REQ-003 Parameter MAX_HOLD, default 8, transfers one master may issue before yielding to a waiting master (range 1..255).
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Ports m0_req / m1_req  input  1  master requests a RAM transfer this cycle.
REQ-007 Ports m0_lock / m1_lock  input  1  master asks to keep ownership after the current transfer.
REQ-008 Ports m0_we / m1_we  input  1  transfer type: 1 = write, 0 = read.
REQ-009 Ports m0_addr / m1_addr  input  AW  byte address.
REQ-010 Ports m0_sel / m1_sel  input  DW/8  byte enables.
REQ-011 Ports m0_wdata / m1_wdata  input  DW  write data.
REQ-012 Ports m0_gnt / m1_gnt  output  1  master owns the RAM this cycle.
REQ-013 Ports m0_rvalid / m1_rvalid  output  1  read data valid for that master.
REQ-014 Ports m0_rdata / m1_rdata  output  DW  read data; both equal ram_rdata.
REQ-015 Ports ram_ce, ram_we, ram_addr, ram_sel, ram_wdata  output  1/1/AW/DW/8/DW  shared RAM port.
REQ-016 Port ram_rdata  input  DW  RAM read data, valid one cycle after the read's ram_ce.

Function
REQ-017 The block SHALL implement states IDLE, OWN0 and OWN1; mX_gnt SHALL be 1 exactly in OWNX, both grants are registered.
REQ-018 A transfer SHALL occur in a cycle with mX_req=1 and mX_gnt=1; ram_ce SHALL be 1 only then, and ram_we/addr/sel/wdata SHALL be the owner's inputs, combinationally muxed.
REQ-019 In IDLE, ram_ce SHALL be 0, and ram_we/addr/sel/wdata SHALL be 0.
REQ-020 Arbitration latency SHALL be one cycle: a request seen in IDLE yields mX_gnt on the next cycle.
REQ-021 In IDLE with one requester, that master SHALL be granted; with both, the master not in the last-granted register SHALL be granted (round-robin).
REQ-022 The last-granted register SHALL update on every entry into OWN0/OWN1.
REQ-023 A per-ownership hold counter SHALL count transfers, clear on every ownership change, and saturate at MAX_HOLD.
REQ-024 In OWNX, ownership SHALL end when mX_req=0 and mX_lock=0, or when the counter, including this cycle's transfer, reaches MAX_HOLD while the other master requests and mX_lock=0.
REQ-025 On ending ownership, the next state SHALL be OWN(other) if the other master requests, else IDLE; there is no idle bubble between owners.
REQ-026 mX_lock=1 SHALL hold ownership regardless of the hold counter or the other master's request, including cycles with mX_req=0.
REQ-027 mX_rvalid SHALL be 1 exactly one cycle after a read transfer by master X (mX_we=0), and 0 otherwise; writes SHALL never raise rvalid.
REQ-028 A read issued in the last owned cycle SHALL still return rvalid to its issuer on the following cycle, even if ownership has changed.
REQ-029 At most one of m0_gnt/m1_gnt and at most one of m0_rvalid/m1_rvalid SHALL be 1 in any cycle.

Reset
REQ-030 While rst=0, the state SHALL be IDLE and last-granted SHALL be 1, so m0 wins the first tie.
REQ-031 While rst=0, the hold counter SHALL be 0, and the gnt, rvalid, ram_ce and ram_we outputs SHALL all be 0.
REQ-032 Reset asserted mid-transfer SHALL take effect immediately (asynchronous): a pending rvalid is dropped and no RAM write occurs after assertion.

Verification
REQ-033 After reset release, both masters request at cycle 0: m0_gnt=1 at cycle 1, and m1 is granted only after m0 drops req or completes 8 transfers.
REQ-034 m0 holds req continuously, m1 requests, MAX_HOLD=8: m0 performs exactly 8 transfers, then m1_gnt=1 on the next cycle with no IDLE cycle.
REQ-035 m1 issues a read of addr 0x10 and the RAM returns 0xDEADBEEF next cycle: m1_rvalid=1, m1_rdata=0xDEADBEEF, and m0_rvalid=0.
REQ-036 m0 has lock=1 for 12 cycles while m1 requests: m0_gnt stays 1 for all 12 cycles; after lock and req drop, m1_gnt=1 on the next cycle.
REQ-037 A write by m0 (addr 0x4, sel 4'b0011, data 0x1234) in its final owned cycle: ram_we=1 with those values, and no rvalid follows.
REQ-038 rst driven low during an m1 read: m1_rvalid, m1_gnt and ram_ce become 0 without a clock edge; after release, the bench sees IDLE and the round-robin pointer back at 1.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bundle of both master ports and the shared RAM port of ram_arbiter.
// The arbiter side uses the slave modport; masters and the RAM model use the master modport.
interface ram_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            m0_req;
    logic            m0_lock;
    logic            m0_we;
    logic [AW-1:0]   m0_addr;
    logic [DW/8-1:0] m0_sel;
    logic [DW-1:0]   m0_wdata;
    logic            m0_gnt;
    logic            m0_rvalid;
    logic [DW-1:0]   m0_rdata;

    logic            m1_req;
    logic            m1_lock;
    logic            m1_we;
    logic [AW-1:0]   m1_addr;
    logic [DW/8-1:0] m1_sel;
    logic [DW-1:0]   m1_wdata;
    logic            m1_gnt;
    logic            m1_rvalid;
    logic [DW-1:0]   m1_rdata;

    logic            ram_ce;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW/8-1:0] ram_sel;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;

    modport slave (
        input  m0_req, m0_lock, m0_we, m0_addr, m0_sel, m0_wdata,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_sel, m1_wdata,
        input  ram_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
    );

    modport master (
        output m0_req, m0_lock, m0_we, m0_addr, m0_sel, m0_wdata,
        output m1_req, m1_lock, m1_we, m1_addr, m1_sel, m1_wdata,
        output ram_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master round-robin RAM arbiter: grant one cycle after request, read data one cycle after the transfer.
// Backpressure: an ungranted master simply holds req; lock or the hold limit decide when ownership yields.
module ram_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t     state, state_nxt;
    logic       last_gnt, last_nxt;
    logic [7:0] hold_cnt, hold_nxt, cnt_after;
    logic       rv0, rv1;
    logic       xfer0, xfer1;

    assign xfer0 = (state == OWN0) && bus.m0_req;
    assign xfer1 = (state == OWN1) && bus.m1_req;

    // Transfer count including this cycle's transfer, saturating at the hold limit.
    assign cnt_after = ((xfer0 || xfer1) && (hold_cnt != HOLD_MAX)) ? hold_cnt + 8'd1 : hold_cnt;

    always_comb begin
        state_nxt = state;
        last_nxt  = last_gnt;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                hold_nxt = 8'd0;
                if (bus.m0_req && (!bus.m1_req || last_gnt)) begin
                    state_nxt = OWN0;
                    last_nxt  = 1'b0;
                end else if (bus.m1_req) begin
                    state_nxt = OWN1;
                    last_nxt  = 1'b1;
                end
            end
            OWN0: begin
                if (!bus.m0_lock && (!bus.m0_req || (bus.m1_req && cnt_after == HOLD_MAX))) begin
                    hold_nxt = 8'd0;
                    if (bus.m1_req) begin
                        state_nxt = OWN1;
                        last_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    hold_nxt = cnt_after;
                end
            end
            OWN1: begin
                if (!bus.m1_lock && (!bus.m1_req || (bus.m0_req && cnt_after == HOLD_MAX))) begin
                    hold_nxt = 8'd0;
                    if (bus.m0_req) begin
                        state_nxt = OWN0;
                        last_nxt  = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    hold_nxt = cnt_after;
                end
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            hold_cnt <= 8'd0;
            rv0      <= 1'b0;
            rv1      <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_nxt;
            hold_cnt <= hold_nxt;
            rv0      <= xfer0 && !bus.m0_we;
            rv1      <= xfer1 && !bus.m1_we;
        end
    end

    // The RAM port follows the current owner even when it is not transferring; IDLE drives zeros.
    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_sel   = '0;
        bus.ram_wdata = '0;
        case (state)
            OWN0: begin
                bus.ram_we    = bus.m0_we;
                bus.ram_addr  = bus.m0_addr;
                bus.ram_sel   = bus.m0_sel;
                bus.ram_wdata = bus.m0_wdata;
            end
            OWN1: begin
                bus.ram_we    = bus.m1_we;
                bus.ram_addr  = bus.m1_addr;
                bus.ram_sel   = bus.m1_sel;
                bus.ram_wdata = bus.m1_wdata;
            end
            default: ;
        endcase
    end

    assign bus.ram_ce    = xfer0 || xfer1;
    assign bus.m0_gnt    = (state == OWN0);
    assign bus.m1_gnt    = (state == OWN1);
    assign bus.m0_rvalid = rv0;
    assign bus.m1_rvalid = rv1;
    assign bus.m0_rdata  = bus.ram_rdata;
    assign bus.m1_rdata  = bus.ram_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic against a cycle-level ownership model.
module tb_ram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus();
    ram_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic idle_inputs();
        bus.m0_req = 0; bus.m0_lock = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_sel = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_lock = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_sel = '0; bus.m1_wdata = '0;
        bus.ram_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 0;
        idle_inputs();
        tick();
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        bus.m0_req = 1; bus.m1_req = 1; bus.m0_we = 1; bus.m1_we = 1;
        sample();
        n_checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.ram_ce, bus.ram_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b ce=%b we=%b required all 0",
                     bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.ram_ce, bus.ram_we);
        end
        tick();
        bus.m0_we = 0;
        n_checks++;
        if (bus.ram_addr !== '0 || bus.ram_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_bus_zero: got addr=%h wdata=%h required 0", bus.ram_addr, bus.ram_wdata);
        end
        tick();
        rst = 1;
    endtask

    // Both masters request from reset release: m0 wins the tie and keeps the RAM for exactly MH transfers.
    task automatic test_tie();
        int  xfers = 0;
        bit  seen  = 0;
        bit  gap   = 0;
        tick();
        sample();
        n_checks++;
        if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_first_grant: got m0_gnt=%b m1_gnt=%b required 1 0", bus.m0_gnt, bus.m1_gnt);
        end
        for (int c = 0; c < 30; c++) begin
            if (bus.m1_gnt) begin
                seen = 1;
                break;
            end
            if (!bus.m0_gnt) gap = 1;
            if (bus.ram_ce) xfers++;
            tick();
            sample();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL tie_m1_grant: got no m1_gnt within 30 cycles required grant");
        end
        n_checks++;
        if (xfers != MH) begin
            n_fail++;
            $display("FAIL tie_m0_xfers: got %0d required %0d", xfers, MH);
        end
        n_checks++;
        if (gap) begin
            n_fail++;
            $display("FAIL tie_no_gap: got idle cycle between owners required none");
        end
    endtask

    task automatic test_hold_limit(input bit last_read);
        logic [31:0] rd;
        do_reset();
        bus.m0_req = 1; bus.m0_we = 1; bus.m1_we = 1;
        tick();
        for (int i = 0; i < MH; i++) begin
            if (i == 2) bus.m1_req = 1;
            bus.m0_addr = $urandom;
            bus.m0_wdata = $urandom;
            bus.m0_sel = 4'hf;
            if (i == MH - 1) begin
                bus.m0_we = !last_read; bus.m0_addr = 32'h4; bus.m0_sel = 4'b0011; bus.m0_wdata = 32'h1234;
            end
            sample();
            n_checks++;
            if (bus.m0_gnt !== 1'b1 || bus.ram_ce !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_owned_%0d: got gnt=%b ce=%b required 1 1", i, bus.m0_gnt, bus.ram_ce);
            end
            if (i == MH - 1 && !last_read) begin
                n_checks++;
                if (bus.ram_we !== 1'b1 || bus.ram_addr !== 32'h4 || bus.ram_sel !== 4'b0011 || bus.ram_wdata !== 32'h1234) begin
                    n_fail++;
                    $display("FAIL final_write: got we=%b addr=%h sel=%b data=%h required 1 4 0011 1234",
                             bus.ram_we, bus.ram_addr, bus.ram_sel, bus.ram_wdata);
                end
            end
            tick();
        end
        rd = $urandom;
        bus.ram_rdata = rd;
        sample();
        n_checks++;
        if (bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL handoff: got m0_gnt=%b m1_gnt=%b required 0 1", bus.m0_gnt, bus.m1_gnt);
        end
        n_checks++;
        if (bus.m0_rvalid !== last_read || bus.m1_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL handoff_rvalid: got m0=%b m1=%b required %b 0", bus.m0_rvalid, bus.m1_rvalid, last_read);
        end
        if (last_read) begin
            n_checks++;
            if (bus.m0_rdata !== rd) begin
                n_fail++;
                $display("FAIL handoff_rdata: got %h required %h", bus.m0_rdata, rd);
            end
        end
        tick();
        sample();
        n_checks++;
        if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rvalid_pulse: got m0=%b m1=%b required 0 0", bus.m0_rvalid, bus.m1_rvalid);
        end
    endtask

    task automatic test_read();
        do_reset();
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h10; bus.m1_sel = 4'hf;
        tick();
        sample();
        n_checks++;
        if (bus.m1_gnt !== 1'b1 || bus.ram_ce !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL read_issue: got gnt=%b ce=%b we=%b addr=%h required 1 1 0 10",
                     bus.m1_gnt, bus.ram_ce, bus.ram_we, bus.ram_addr);
        end
        tick();
        bus.m1_req = 0;
        bus.ram_rdata = 32'hDEADBEEF;
        sample();
        n_checks++;
        if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 32'hDEADBEEF || bus.m0_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_return: got m1_rvalid=%b m1_rdata=%h m0_rvalid=%b required 1 deadbeef 0",
                     bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid);
        end
        tick();
        sample();
        n_checks++;
        if (bus.m1_rvalid !== 1'b0 || bus.m1_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done: got rvalid=%b gnt=%b required 0 0", bus.m1_rvalid, bus.m1_gnt);
        end
    endtask

    task automatic test_lock();
        do_reset();
        bus.m0_req = 1; bus.m0_lock = 1; bus.m0_we = 1; bus.m1_we = 1;
        tick();
        bus.m1_req = 1;
        for (int i = 0; i < 12; i++) begin
            bus.m0_req = 1'($urandom_range(0, 1));
            sample();
            n_checks++;
            if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_hold_%0d: got m0_gnt=%b m1_gnt=%b required 1 0", i, bus.m0_gnt, bus.m1_gnt);
            end
            tick();
        end
        bus.m0_req = 0; bus.m0_lock = 0;
        tick();
        sample();
        n_checks++;
        if (bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_release: got m0_gnt=%b m1_gnt=%b required 0 1", bus.m0_gnt, bus.m1_gnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h20;
        tick();
        tick();
        #2;
        rst = 0;
        #1;
        n_checks++;
        if (bus.m1_rvalid !== 1'b0 || bus.m1_gnt !== 1'b0 || bus.ram_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got rvalid=%b gnt=%b ce=%b required 0 0 0",
                     bus.m1_rvalid, bus.m1_gnt, bus.ram_ce);
        end
        idle_inputs();
        tick();
        rst = 1;
        sample();
        n_checks++;
        if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got gnt=%b%b required 00", bus.m0_gnt, bus.m1_gnt);
        end
        tick();
        // Leave m0 as last granted so only a reset can bring the pointer back to m1.
        bus.m0_req = 1;
        tick();
        bus.m0_req = 0;
        tick();
        rst = 0;
        tick();
        rst = 1;
        bus.m0_req = 1; bus.m1_req = 1; bus.m0_we = 1; bus.m1_we = 1;
        tick();
        sample();
        n_checks++;
        if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL pointer_reset: got m0_gnt=%b m1_gnt=%b required 1 0", bus.m0_gnt, bus.m1_gnt);
        end
    endtask

    task automatic test_random();
        int          owner = -1;
        int          mlast = 1;
        int          mcnt  = 0;
        bit          mrv[2] = '{0, 0};
        bit          r[2], l[2], w[2];
        logic [31:0] a[2];
        logic [31:0] rd;
        int          t, o;
        logic [5:0]  got, exp;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                r[m] = ($urandom_range(0, 9) < 7);
                l[m] = ($urandom_range(0, 9) == 0);
                w[m] = 1'($urandom);
                a[m] = $urandom;
            end
            rd = $urandom;
            bus.m0_req = r[0]; bus.m0_lock = l[0]; bus.m0_we = w[0]; bus.m0_addr = a[0];
            bus.m1_req = r[1]; bus.m1_lock = l[1]; bus.m1_we = w[1]; bus.m1_addr = a[1];
            bus.m0_sel = 4'($urandom); bus.m1_sel = 4'($urandom);
            bus.m0_wdata = $urandom; bus.m1_wdata = $urandom;
            bus.ram_rdata = rd;
            sample();
            exp = {owner == 0, owner == 1, owner >= 0 && r[owner >= 0 ? owner : 0],
                   mrv[0], mrv[1], owner >= 0 && w[owner >= 0 ? owner : 0]};
            got = {bus.m0_gnt, bus.m1_gnt, bus.ram_ce, bus.m0_rvalid, bus.m1_rvalid, bus.ram_we};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand_ctrl cycle %0d: got gnt/gnt/ce/rv/rv/we=%b required %b", cyc, got, exp);
            end
            n_checks++;
            if (bus.ram_addr !== (owner >= 0 ? a[owner >= 0 ? owner : 0] : 32'h0)) begin
                n_fail++;
                $display("FAIL rand_addr cycle %0d: got %h owner %0d", cyc, bus.ram_addr, owner);
            end
            if (mrv[0] || mrv[1]) begin
                n_checks++;
                if ((mrv[0] ? bus.m0_rdata : bus.m1_rdata) !== rd) begin
                    n_fail++;
                    $display("FAIL rand_rdata cycle %0d: got %h required %h", cyc,
                             mrv[0] ? bus.m0_rdata : bus.m1_rdata, rd);
                end
            end
            // Advance the reference: reads return next cycle; ownership follows the grant/yield rules.
            mrv[0] = (owner == 0) && r[0] && !w[0];
            mrv[1] = (owner == 1) && r[1] && !w[1];
            if (owner < 0) begin
                if (r[0] && r[1]) owner = (mlast == 1) ? 0 : 1;
                else if (r[0]) owner = 0;
                else if (r[1]) owner = 1;
                if (owner >= 0) mlast = owner;
                mcnt = 0;
            end else begin
                o = owner;
                t = mcnt + (r[o] ? 1 : 0);
                if (t > MH) t = MH;
                if (!l[o] && (!r[o] || (r[1-o] && t >= MH))) begin
                    owner = r[1-o] ? 1 - o : -1;
                    if (owner >= 0) mlast = owner;
                    mcnt = 0;
                end else begin
                    mcnt = t;
                end
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_tie();
        test_hold_limit(1'b0);
        test_hold_limit(1'b1);
        test_read();
        test_lock();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
